// File: rtl/ceyloniac_pkg.sv
// ceyloniac_pkg: shared ALU opcodes, width defaults and register-zero constant
package ceyloniac_pkg;
  localparam int DEF_ALU_DATA_WIDTH = 32;
  localparam int DEF_ALU_OP_WIDTH   = 4;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_IMM_WIDTH      = 16;
  localparam logic [DEF_REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_NOR  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_MUL  = 4'b1011,
    ALU_LUI  = 4'b1100,
    ALU_ROL  = 4'b1101,
    ALU_ROR  = 4'b1110,
    ALU_PASS = 4'b1111
  } alu_op_e;
endpackage

// File: rtl/ceyloniac_fwd_mux.sv
// ceyloniac_fwd_mux: picks the newest in-flight value for one source register
module ceyloniac_fwd_mux
  import ceyloniac_pkg::*;
#(
  parameter int DW = DEF_ALU_DATA_WIDTH,
  parameter int AW = DEF_REG_ADDR_WIDTH
) (
  input  logic [AW-1:0] i_src,
  input  logic [DW-1:0] i_rf_data,
  input  logic          i_ex_en,
  input  logic [AW-1:0] i_ex_rd,
  input  logic [DW-1:0] i_ex_data,
  input  logic          i_exmem_en,
  input  logic [AW-1:0] i_exmem_rd,
  input  logic [DW-1:0] i_exmem_data,
  input  logic          i_memwb_en,
  input  logic [AW-1:0] i_memwb_rd,
  input  logic [DW-1:0] i_memwb_data,
  output logic [DW-1:0] o_data
);
  logic w_nz;
  assign w_nz = i_src != '0;
  // Youngest producer wins; r0 is hard-wired so never forwarded
  assign o_data = !w_nz                               ? i_rf_data    :
                  (i_ex_en    && i_ex_rd    == i_src) ? i_ex_data    :
                  (i_exmem_en && i_exmem_rd == i_src) ? i_exmem_data :
                  (i_memwb_en && i_memwb_rd == i_src) ? i_memwb_data :
                                                        i_rf_data;
endmodule

// File: rtl/ceyloniac_id_ex_stage.sv
// ceyloniac_id_ex_stage: one-entry ID/EX register with forwarding,
// immediate selection and a saturating stall counter
module ceyloniac_id_ex_stage
  import ceyloniac_pkg::*;
#(
  parameter int ALU_DATA_WIDTH = DEF_ALU_DATA_WIDTH,
  parameter int ALU_OP_WIDTH   = DEF_ALU_OP_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int IMM_WIDTH      = DEF_IMM_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_id_valid,
  output logic                      o_id_ready,
  input  logic [ALU_OP_WIDTH-1:0]   i_id_alu_sel,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rt_addr,
  input  logic [ALU_DATA_WIDTH-1:0] i_id_rs_data,
  input  logic [ALU_DATA_WIDTH-1:0] i_id_rt_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
  input  logic                      i_id_wr_en,
  input  logic [IMM_WIDTH-1:0]      i_id_imm,
  input  logic                      i_id_use_imm,
  input  logic                      i_id_imm_signed,
  input  logic [ALU_DATA_WIDTH-1:0] i_alu_result,
  input  logic                      i_exmem_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_exmem_rd_addr,
  input  logic [ALU_DATA_WIDTH-1:0] i_exmem_data,
  input  logic                      i_memwb_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_memwb_rd_addr,
  input  logic [ALU_DATA_WIDTH-1:0] i_memwb_data,
  input  logic                      i_flush,
  output logic                      o_ex_valid,
  input  logic                      i_ex_ready,
  output logic [ALU_DATA_WIDTH-1:0] o_alu_in_a,
  output logic [ALU_DATA_WIDTH-1:0] o_alu_in_b,
  output logic [ALU_OP_WIDTH-1:0]   o_alu_sel,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
  output logic                      o_ex_wr_en,
  output logic [31:0]               o_stall_count
);
  logic                      r_ex_valid;
  logic [ALU_DATA_WIDTH-1:0] r_alu_a;
  logic [ALU_DATA_WIDTH-1:0] r_alu_b;
  logic [ALU_OP_WIDTH-1:0]   r_alu_sel;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
  logic                      r_wr_en;
  logic [31:0]               r_stall;
  logic                      w_id_ready;
  logic                      w_cap;
  logic                      w_ex_fwd_en;
  logic [ALU_DATA_WIDTH-1:0] w_imm_ext;
  logic [ALU_DATA_WIDTH-1:0] w_fwd_a;
  logic [ALU_DATA_WIDTH-1:0] w_fwd_b;
  assign w_id_ready  = !r_ex_valid || i_ex_ready;
  assign w_cap       = i_id_valid && w_id_ready && !i_flush;
  assign w_ex_fwd_en = r_ex_valid && r_wr_en;
  assign w_imm_ext   = {{(ALU_DATA_WIDTH-IMM_WIDTH){i_id_imm_signed & i_id_imm[IMM_WIDTH-1]}}, i_id_imm};
  ceyloniac_fwd_mux #(.DW(ALU_DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_fwd_rs (
    .i_src       (i_id_rs_addr),
    .i_rf_data   (i_id_rs_data),
    .i_ex_en     (w_ex_fwd_en),
    .i_ex_rd     (r_rd_addr),
    .i_ex_data   (i_alu_result),
    .i_exmem_en  (i_exmem_wr_en),
    .i_exmem_rd  (i_exmem_rd_addr),
    .i_exmem_data(i_exmem_data),
    .i_memwb_en  (i_memwb_wr_en),
    .i_memwb_rd  (i_memwb_rd_addr),
    .i_memwb_data(i_memwb_data),
    .o_data      (w_fwd_a)
  );
  ceyloniac_fwd_mux #(.DW(ALU_DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_fwd_rt (
    .i_src       (i_id_rt_addr),
    .i_rf_data   (i_id_rt_data),
    .i_ex_en     (w_ex_fwd_en),
    .i_ex_rd     (r_rd_addr),
    .i_ex_data   (i_alu_result),
    .i_exmem_en  (i_exmem_wr_en),
    .i_exmem_rd  (i_exmem_rd_addr),
    .i_exmem_data(i_exmem_data),
    .i_memwb_en  (i_memwb_wr_en),
    .i_memwb_rd  (i_memwb_rd_addr),
    .i_memwb_data(i_memwb_data),
    .o_data      (w_fwd_b)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_stall    <= '0;
    end else begin
      if (i_flush) r_ex_valid <= 1'b0;
      else if (w_cap) r_ex_valid <= 1'b1;
      else if (i_ex_ready) r_ex_valid <= 1'b0;
      if (w_cap) begin
        r_alu_a   <= w_fwd_a;
        r_alu_b   <= i_id_use_imm ? w_imm_ext : w_fwd_b;
        r_alu_sel <= i_id_alu_sel;
        r_rd_addr <= i_id_rd_addr;
        r_wr_en   <= i_id_wr_en && (i_id_rd_addr != REG_ADDR_WIDTH'(REG_ZERO));
      end
      if (r_ex_valid && !i_ex_ready && r_stall != '1) r_stall <= r_stall + 32'd1;
    end
  end
  assign o_id_ready    = w_id_ready;
  assign o_ex_valid    = r_ex_valid;
  assign o_alu_in_a    = r_alu_a;
  assign o_alu_in_b    = r_alu_b;
  assign o_alu_sel     = r_alu_sel;
  assign o_ex_rd_addr  = r_rd_addr;
  assign o_ex_wr_en    = r_wr_en;
  assign o_stall_count = r_stall;
endmodule

// File: tb/tb_ceyloniac_id_ex_stage.sv
// tb_ceyloniac_id_ex_stage: directed vector table, hand-written stall/reset
// sequences and randomized traffic against a reference model
module tb_ceyloniac_id_ex_stage;
  logic        clk, rst_n;
  logic        id_valid, id_ready, id_wr_en, id_use_imm, id_imm_signed;
  logic [3:0]  id_alu_sel;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, alu_result;
  logic [15:0] id_imm;
  logic        exmem_wr_en, memwb_wr_en, flush, ex_valid, ex_ready, ex_wr_en;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr, ex_rd_addr;
  logic [31:0] exmem_data, memwb_data, alu_in_a, alu_in_b, stall_count;
  logic [3:0]  alu_sel;

  ceyloniac_id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(id_valid), .o_id_ready(id_ready),
    .i_id_alu_sel(id_alu_sel),
    .i_id_rs_addr(id_rs_addr), .i_id_rt_addr(id_rt_addr),
    .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data),
    .i_id_rd_addr(id_rd_addr), .i_id_wr_en(id_wr_en),
    .i_id_imm(id_imm), .i_id_use_imm(id_use_imm), .i_id_imm_signed(id_imm_signed),
    .i_alu_result(alu_result),
    .i_exmem_wr_en(exmem_wr_en), .i_exmem_rd_addr(exmem_rd_addr), .i_exmem_data(exmem_data),
    .i_memwb_wr_en(memwb_wr_en), .i_memwb_rd_addr(memwb_rd_addr), .i_memwb_data(memwb_data),
    .i_flush(flush), .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
    .o_alu_in_a(alu_in_a), .o_alu_in_b(alu_in_b), .o_alu_sel(alu_sel),
    .o_ex_rd_addr(ex_rd_addr), .o_ex_wr_en(ex_wr_en), .o_stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic idv, fl, exr;
    logic [3:0] sel;
    logic [4:0] rs, rt;
    logic [31:0] rsd, rtd;
    logic [4:0] rd;
    logic we;
    logic [15:0] imm;
    logic ui, is;
    logic [31:0] alu;
    logic xw; logic [4:0] xr; logic [31:0] xd;
    logic mw; logic [4:0] mr; logic [31:0] md;
    logic ev; logic [31:0] ea, eb; logic [3:0] es; logic [4:0] erd; logic ewe;
  } vec_t;

  task automatic apply(input vec_t v);
    id_valid = v.idv; flush = v.fl; ex_ready = v.exr; id_alu_sel = v.sel;
    id_rs_addr = v.rs; id_rt_addr = v.rt; id_rs_data = v.rsd; id_rt_data = v.rtd;
    id_rd_addr = v.rd; id_wr_en = v.we; id_imm = v.imm; id_use_imm = v.ui;
    id_imm_signed = v.is; alu_result = v.alu;
    exmem_wr_en = v.xw; exmem_rd_addr = v.xr; exmem_data = v.xd;
    memwb_wr_en = v.mw; memwb_rd_addr = v.mr; memwb_data = v.md;
  endtask

  task automatic idle();
    id_valid = 0; flush = 0; ex_ready = 1; id_alu_sel = 0; id_rs_addr = 0; id_rt_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_rd_addr = 0; id_wr_en = 0; id_imm = 0;
    id_use_imm = 0; id_imm_signed = 0; alu_result = 0; exmem_wr_en = 0; exmem_rd_addr = 0;
    exmem_data = 0; memwb_wr_en = 0; memwb_rd_addr = 0; memwb_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: what the stage should currently be presenting
  logic        m_v, m_we;
  logic [31:0] m_a, m_b, m_st;
  logic [3:0]  m_s;
  logic [4:0]  m_rd;

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    m_v = 0; m_we = 0; m_a = 0; m_b = 0; m_st = 0; m_s = 0; m_rd = 0;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
    logic        en[3];
    logic [4:0]  tg[3];
    logic [31:0] dv[3];
    en = '{m_v && m_we, exmem_wr_en, memwb_wr_en};
    tg = '{m_rd, exmem_rd_addr, memwb_rd_addr};
    dv = '{alu_result, exmem_data, memwb_data};
    if (src == 0) return rf;
    for (int i = 0; i < 3; i++)
      if (en[i] && tg[i] == src) return dv[i];
    return rf;
  endfunction

  task automatic model_step();
    logic        cap;
    logic [31:0] immx;
    cap = id_valid && (!m_v || ex_ready) && !flush;
    immx = id_imm_signed ? 32'(signed'(id_imm)) : 32'(id_imm);
    if (m_v && !ex_ready && m_st != 32'hFFFF_FFFF) m_st = m_st + 1;
    if (cap) begin
      m_a  = fwd(id_rs_addr, id_rs_data);
      m_b  = id_use_imm ? immx : fwd(id_rt_addr, id_rt_data);
      m_s  = id_alu_sel;
      m_rd = id_rd_addr;
      m_we = id_wr_en && id_rd_addr != 0;
      m_v  = 1;
    end else if (flush || ex_ready) m_v = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " ex_valid"}, 32'(ex_valid), 32'(m_v));
    chk({tag, " alu_in_a"}, alu_in_a, m_a);
    chk({tag, " alu_in_b"}, alu_in_b, m_b);
    chk({tag, " alu_sel"}, 32'(alu_sel), 32'(m_s));
    chk({tag, " ex_rd_addr"}, 32'(ex_rd_addr), 32'(m_rd));
    chk({tag, " ex_wr_en"}, 32'(ex_wr_en), 32'(m_we));
    chk({tag, " stall_count"}, stall_count, m_st);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1,0,1, 4'h0, 5'd1,5'd2, 32'h5,32'h7, 5'd3,1, 16'h0,0,0, 32'h0,
               0,5'd0,32'h0, 0,5'd0,32'h0, 1,32'h5,32'h7,4'h0,5'd3,1};
    tbl[1] = '{1,0,1, 4'h1, 5'd3,5'd2, 32'h0,32'h7, 5'd5,1, 16'h0,0,0, 32'h10,
               1,5'd3,32'h20, 0,5'd0,32'h0, 1,32'h10,32'h7,4'h1,5'd5,1};
    tbl[2] = '{1,0,1, 4'h2, 5'd1,5'd5, 32'h9,32'h0, 5'd6,1, 16'hFFF0,1,1, 32'h33,
               0,5'd0,32'h0, 0,5'd0,32'h0, 1,32'h9,32'hFFFF_FFF0,4'h2,5'd6,1};
    tbl[3] = '{1,0,1, 4'h3, 5'd6,5'd0, 32'h0,32'h0, 5'd7,1, 16'hFFF0,1,0, 32'h44,
               0,5'd0,32'h0, 0,5'd0,32'h0, 1,32'h44,32'h0000_FFF0,4'h3,5'd7,1};
    tbl[4] = '{1,0,1, 4'h4, 5'd2,5'd8, 32'h11,32'h22, 5'd0,1, 16'h0,0,0, 32'h0,
               0,5'd0,32'h0, 1,5'd8,32'h88, 1,32'h11,32'h88,4'h4,5'd0,0};
    tbl[5] = '{1,0,1, 4'hF, 5'd0,5'd0, 32'h99,32'h12, 5'd9,0, 16'h0,0,0, 32'hAA,
               1,5'd0,32'h55, 1,5'd0,32'h66, 1,32'h99,32'h12,4'hF,5'd9,0};
    tbl[6] = '{1,0,1, 4'h5, 5'd4,5'd4, 32'h1,32'h2, 5'd10,1, 16'h0,0,0, 32'hBB,
               1,5'd4,32'h40, 1,5'd4,32'h41, 1,32'h40,32'h40,4'h5,5'd10,1};
    tbl[7] = '{1,1,1, 4'h7, 5'd1,5'd1, 32'h77,32'h77, 5'd12,1, 16'h0,0,0, 32'h0,
               0,5'd0,32'h0, 0,5'd0,32'h0, 0,32'h40,32'h40,4'h5,5'd10,1};
    tbl[8] = '{0,0,1, 4'h0, 5'd0,5'd0, 32'h0,32'h0, 5'd0,0, 16'h0,0,0, 32'h0,
               0,5'd0,32'h0, 0,5'd0,32'h0, 0,32'h40,32'h40,4'h5,5'd10,1};
    tbl[9] = '{1,0,1, 4'h6, 5'd10,5'd0, 32'h3,32'h0, 5'd11,1, 16'h0,0,0, 32'hDEAD,
               0,5'd0,32'h0, 0,5'd0,32'h0, 1,32'h3,32'h0,4'h6,5'd11,1};

    do_reset();
    chk("reset ex_valid", 32'(ex_valid), 0);
    chk("reset alu_in_a", alu_in_a, 0);
    chk("reset stall_count", stall_count, 0);
    chk("reset id_ready", 32'(id_ready), 1);

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      tick();
      chk($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d alu_in_a", i), alu_in_a, tbl[i].ea);
      chk($sformatf("vec%0d alu_in_b", i), alu_in_b, tbl[i].eb);
      chk($sformatf("vec%0d alu_sel", i), 32'(alu_sel), 32'(tbl[i].es));
      chk($sformatf("vec%0d ex_rd_addr", i), 32'(ex_rd_addr), 32'(tbl[i].erd));
      chk($sformatf("vec%0d ex_wr_en", i), 32'(ex_wr_en), 32'(tbl[i].ewe));
    end

    // Backpressure: three stalled cycles, then release takes the waiting instruction
    do_reset();
    id_valid = 1; ex_ready = 1; id_rs_addr = 1; id_rs_data = 32'hA;
    id_rt_addr = 2; id_rt_data = 32'hB; id_rd_addr = 3; id_wr_en = 1;
    tick();
    chk("bp first ex_valid", 32'(ex_valid), 1);
    chk("bp first alu_in_a", alu_in_a, 32'hA);
    ex_ready = 0; id_rs_data = 32'hC; id_rt_data = 32'hD; id_rd_addr = 4;
    #1;
    chk("bp id_ready low", 32'(id_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp hold%0d alu_in_a", i), alu_in_a, 32'hA);
      chk($sformatf("bp hold%0d alu_in_b", i), alu_in_b, 32'hB);
      chk($sformatf("bp hold%0d ex_rd_addr", i), 32'(ex_rd_addr), 3);
      chk($sformatf("bp hold%0d id_ready", i), 32'(id_ready), 0);
    end
    chk("bp stall_count", stall_count, 3);
    ex_ready = 1;
    #1;
    chk("bp release id_ready", 32'(id_ready), 1);
    tick();
    chk("bp release alu_in_a", alu_in_a, 32'hC);
    chk("bp release alu_in_b", alu_in_b, 32'hD);
    chk("bp release ex_valid", 32'(ex_valid), 1);
    chk("bp release stall_count", stall_count, 3);

    // Asynchronous reset while stalled
    ex_ready = 0;
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("arst ex_valid", 32'(ex_valid), 0);
    chk("arst alu_in_a", alu_in_a, 0);
    chk("arst alu_in_b", alu_in_b, 0);
    chk("arst alu_sel", 32'(alu_sel), 0);
    chk("arst ex_rd_addr", 32'(ex_rd_addr), 0);
    chk("arst ex_wr_en", 32'(ex_wr_en), 0);
    chk("arst stall_count", stall_count, 0);
    chk("arst id_ready", 32'(id_ready), 1);
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic with small register range to provoke hazards
    do_reset();
    for (int i = 0; i < 600; i++) begin
      id_valid = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 9) == 0;
      ex_ready = $urandom_range(0, 3) != 0;
      id_alu_sel = 4'($urandom);
      id_rs_addr = 5'($urandom_range(0, 3));
      id_rt_addr = 5'($urandom_range(0, 3));
      id_rd_addr = 5'($urandom_range(0, 3));
      id_rs_data = $urandom; id_rt_data = $urandom;
      id_wr_en = 1'($urandom); id_imm = 16'($urandom);
      id_use_imm = $urandom_range(0, 2) == 0; id_imm_signed = 1'($urandom);
      alu_result = $urandom;
      exmem_wr_en = 1'($urandom); exmem_rd_addr = 5'($urandom_range(0, 3)); exmem_data = $urandom;
      memwb_wr_en = 1'($urandom); memwb_rd_addr = 5'($urandom_range(0, 3)); memwb_data = $urandom;
      #1;
      chk("rnd id_ready", 32'(id_ready), 32'(!m_v || ex_ready));
      model_step();
      tick();
      chk_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
